// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (core/debug) arbiter onto a single-ported memory
// Optional round-robin arbitration with macro ARB_ROUND_ROBIN_EN; fixed core priority otherwise.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_rd_en,
    output logic              m_wr_en,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              lat_we;
    logic              lat_dbg;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              grant;
    logic              pick_dbg;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_dbg;

    // On contention the port that did not win last time goes first.
    assign pick_dbg = d_req & (~c_req | ~last_dbg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_dbg <= 1'b1;
        end else if (grant) begin
            last_dbg <= pick_dbg;
        end
    end
`else
    assign pick_dbg = d_req & ~c_req;
`endif

    // rst gates the grant so it drops immediately while reset is asserted.
    assign grant = rst & (state == S_IDLE) & (c_req | d_req);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            lat_we    <= 1'b0;
            lat_dbg   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                lat_dbg   <= pick_dbg;
                lat_we    <= pick_dbg ? d_we    : c_we;
                lat_addr  <= pick_dbg ? d_addr  : c_addr;
                lat_wdata <= pick_dbg ? d_wdata : c_wdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        c_gnt     = grant & ~pick_dbg;
        d_gnt     = grant & pick_dbg;
        c_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        c_rdata   = '0;
        d_rdata   = '0;
        m_rd_en   = 1'b0;
        m_wr_en   = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        case (state)
            S_IDLE: begin
                if (grant) state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                m_rd_en   = ~lat_we;
                m_wr_en   = lat_we;
                m_addr    = lat_addr;
                m_wdata   = lat_wdata;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                // The rvalid pulse doubles as the write acknowledge, with rdata zeroed.
                c_rvalid  = ~lat_dbg;
                d_rvalid  = lat_dbg;
                c_rdata   = (!lat_dbg && !lat_we) ? m_rdata : '0;
                d_rdata   = (lat_dbg && !lat_we)  ? m_rdata : '0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy    = (state != S_IDLE);
    assign c_stall = (c_req & ~c_rvalid) | (busy & ~lat_dbg & ~c_rvalid);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_rvalid, c_stall, d_gnt, d_rvalid;
    logic [31:0] c_rdata, d_rdata;
    logic        m_rd_en, m_wr_en, busy;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [31:0] mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_stall(c_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_rd_en(m_rd_en), .m_wr_en(m_wr_en), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy)
    );

    // Memory model: read data appears the cycle after m_rd_en.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h10] <= 32'hDEADBEEF;
            m_rdata    <= 32'h0;
        end else begin
            if (m_wr_en) mem[m_addr[7:0]] <= m_wdata;
            if (m_rd_en) m_rdata <= mem[m_addr[7:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        step(); step();
        settle();
        check("rst_c_gnt", {31'b0, c_gnt}, 32'd0);
        check("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_m_en", {30'b0, m_rd_en, m_wr_en}, 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        c_req = 1'b0; d_req = 1'b0;
        step();
        rst = 1'b1;

        // Core read of 0x10
        step();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
        settle();
        check("cr_c_gnt_c0", {31'b0, c_gnt}, 32'd1);
        check("cr_d_gnt_c0", {31'b0, d_gnt}, 32'd0);
        check("cr_busy_c0", {31'b0, busy}, 32'd0);
        step();
        c_req = 1'b0;
        settle();
        check("cr_m_rd_en_c1", {31'b0, m_rd_en}, 32'd1);
        check("cr_m_wr_en_c1", {31'b0, m_wr_en}, 32'd0);
        check("cr_m_addr_c1", m_addr, 32'h10);
        check("cr_busy_c1", {31'b0, busy}, 32'd1);
        check("cr_stall_c1", {31'b0, c_stall}, 32'd1);
        step();
        settle();
        check("cr_c_rvalid_c2", {31'b0, c_rvalid}, 32'd1);
        check("cr_c_rdata_c2", c_rdata, 32'hDEADBEEF);
        check("cr_c_stall_c2", {31'b0, c_stall}, 32'd0);
        check("cr_d_rvalid_c2", {31'b0, d_rvalid}, 32'd0);
        check("cr_m_rd_en_c2", {31'b0, m_rd_en}, 32'd0);
        step();
        settle();
        check("cr_busy_c3", {31'b0, busy}, 32'd0);
        check("cr_m_addr_c3", m_addr, 32'd0);

        // Debug write of 0x12345678 to 0x20
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
        settle();
        check("dw_d_gnt_c0", {31'b0, d_gnt}, 32'd1);
        check("dw_c_gnt_c0", {31'b0, c_gnt}, 32'd0);
        step();
        d_req = 1'b0;
        settle();
        check("dw_m_wr_en_c1", {31'b0, m_wr_en}, 32'd1);
        check("dw_m_rd_en_c1", {31'b0, m_rd_en}, 32'd0);
        check("dw_m_addr_c1", m_addr, 32'h20);
        check("dw_m_wdata_c1", m_wdata, 32'h12345678);
        check("dw_c_stall_c1", {31'b0, c_stall}, 32'd0);
        step();
        settle();
        check("dw_d_rvalid_c2", {31'b0, d_rvalid}, 32'd1);
        check("dw_d_rdata_c2", d_rdata, 32'd0);
        check("dw_c_rvalid_c2", {31'b0, c_rvalid}, 32'd0);
        step();

        // Core reads back the written word
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h20;
        settle();
        check("rb_c_gnt", {31'b0, c_gnt}, 32'd1);
        step();
        c_req = 1'b0;
        step();
        settle();
        check("rb_c_rdata", c_rdata, 32'h12345678);
        step();

        // Debug read of 0x10 leaves debug as the last winner
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        settle();
        check("dr_d_gnt", {31'b0, d_gnt}, 32'd1);
        step();
        d_req = 1'b0;
        step();
        settle();
        check("dr_d_rvalid", {31'b0, d_rvalid}, 32'd1);
        check("dr_d_rdata", d_rdata, 32'hDEADBEEF);
        check("dr_c_rdata", c_rdata, 32'd0);
        step();

        // Contention: both requests held over four accesses
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        for (int i = 0; i < 4; i++) begin
            logic exp_dbg;
`ifdef ARB_ROUND_ROBIN_EN
            exp_dbg = (i % 2) == 1;
`else
            exp_dbg = 1'b0;
`endif
            settle();
            check($sformatf("ct_c_gnt_%0d", i), {31'b0, c_gnt}, {31'b0, ~exp_dbg});
            check($sformatf("ct_d_gnt_%0d", i), {31'b0, d_gnt}, {31'b0, exp_dbg});
            step();
            if (i == 3) begin
                c_req = 1'b0;
                d_req = 1'b0;
            end
            settle();
            check($sformatf("ct_m_addr_%0d", i), m_addr, exp_dbg ? 32'h20 : 32'h10);
            step();
            settle();
            check($sformatf("ct_c_rvalid_%0d", i), {31'b0, c_rvalid}, {31'b0, ~exp_dbg});
            check($sformatf("ct_d_rvalid_%0d", i), {31'b0, d_rvalid}, {31'b0, exp_dbg});
            step();
        end
        settle();
        check("ct_idle_after", {31'b0, busy}, 32'd0);

        // Late debug request raised during a core write access
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h30; c_wdata = 32'hA5A5A5A5;
        settle();
        check("lr_c_gnt", {31'b0, c_gnt}, 32'd1);
        step();
        c_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
        settle();
        check("lr_d_gnt_access", {31'b0, d_gnt}, 32'd0);
        step();
        settle();
        check("lr_d_gnt_resp", {31'b0, d_gnt}, 32'd0);
        check("lr_c_rvalid", {31'b0, c_rvalid}, 32'd1);
        check("lr_c_rdata_wr", c_rdata, 32'd0);
        step();
        settle();
        check("lr_d_gnt_idle", {31'b0, d_gnt}, 32'd1);
        step();
        d_req = 1'b0;
        step();
        settle();
        check("lr_d_rdata", d_rdata, 32'hA5A5A5A5);
        step();

        // Reset asserted in the middle of a write access
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h40; c_wdata = 32'h0BADF00D;
        settle();
        check("ra_c_gnt", {31'b0, c_gnt}, 32'd1);
        step();
        c_req = 1'b0;
        settle();
        check("ra_m_wr_en_before", {31'b0, m_wr_en}, 32'd1);
        rst = 1'b0;
        settle();
        check("ra_m_wr_en_async", {31'b0, m_wr_en}, 32'd0);
        check("ra_m_addr_async", m_addr, 32'd0);
        check("ra_busy_async", {31'b0, busy}, 32'd0);
        step();
        settle();
        check("ra_no_rvalid", {30'b0, c_rvalid, d_rvalid}, 32'd0);
        step();
        rst = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        settle();
        check("ra_d_gnt_release", {31'b0, d_gnt}, 32'd1);
        step();
        d_req = 1'b0;
        step();
        settle();
        check("ra_d_rdata", d_rdata, 32'hDEADBEEF);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: width of every address port.
REQ-002 SHALL have parameter DATA_W, default 32: width of every data port.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have core-side inputs: c_req (1), c_we (1), c_addr (ADDR_W), c_wdata (DATA_W).
REQ-006 SHALL have core-side outputs: c_gnt (1), c_rvalid (1), c_rdata (DATA_W), c_stall (1).
REQ-007 SHALL have debug-side inputs: d_req (1), d_we (1), d_addr (ADDR_W), d_wdata (DATA_W).
REQ-008 SHALL have debug-side outputs: d_gnt (1), d_rvalid (1), d_rdata (DATA_W).
REQ-009 SHALL have memory-side outputs: m_rd_en (1), m_wr_en (1), m_addr (ADDR_W), m_wdata (DATA_W).
REQ-010 SHALL have memory-side input m_rdata (DATA_W), valid one cycle after m_rd_en.
REQ-011 SHALL have output busy (1): high whenever the state is not IDLE.

Function
REQ-012 SHALL implement the three-state FSM IDLE -> ACCESS -> RESP -> IDLE, one cycle in each of ACCESS and RESP.
REQ-013 In IDLE with at least one req high, SHALL pick one winner and assert its gnt combinationally for exactly that cycle.
REQ-014 SHALL latch the winner's we, addr and wdata on the gnt edge and move to ACCESS.
REQ-015 In ACCESS, SHALL drive m_addr and m_wdata from the latch, with m_wr_en=we and m_rd_en=~we, for exactly one cycle.
REQ-016 In RESP, SHALL pulse the winner's rvalid for one cycle, and drive its rdata=m_rdata for a read or 0 for a write.
REQ-017 The rvalid pulse on a write SHALL serve as the write acknowledge.
REQ-018 The non-winner's gnt, rvalid and rdata SHALL remain 0 throughout the access.
REQ-019 Outside ACCESS, m_rd_en and m_wr_en SHALL be 0, and m_addr and m_wdata SHALL be 0.
REQ-020 Requests raised during ACCESS or RESP SHALL wait and be arbitrated in the next IDLE cycle; they SHALL never be dropped while req is held.
REQ-021 A requester SHALL hold req until gnt; req held high after gnt SHALL be treated as a new request.
REQ-022 A req that falls in IDLE before being granted SHALL cause no access.
REQ-023 c_stall SHALL equal c_req & ~c_rvalid, or (state!=IDLE & winner==core & ~c_rvalid).
REQ-024 Access latency from gnt to rvalid SHALL be exactly 2 cycles.
REQ-025 Peak throughput SHALL be 1 access per 3 cycles.
REQ-026 Addresses and data SHALL pass through unmodified, with no alignment checks.
REQ-027 SHALL hold a last_winner register, updated on every grant.

Reset
REQ-028 rst low SHALL immediately force: state=IDLE, all gnt, rvalid and rdata outputs =0, m_* outputs =0, busy=0, latches=0, last_winner=DEBUG.
REQ-029 Reset during ACCESS or RESP SHALL abort the access: no rvalid, and the memory enable drops asynchronously.
REQ-030 Normal arbitration SHALL resume on the first rising edge after rst returns high.

Configuration
REQ-031 With macro ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the port that is not last_winner, which alternates core and debug.
REQ-032 Without ARB_ROUND_ROBIN_EN, simultaneous requests SHALL always go to core (fixed priority), and last_winner SHALL be unused.
REQ-033 A lone requester SHALL be granted immediately in both configurations.

Verification
REQ-034 Core read: c_req=1, c_we=0, c_addr=0x10, memory holds 0xDEADBEEF at 0x10. Required: c_gnt in cycle 0, m_rd_en in cycle 1, c_rvalid=1 with c_rdata=0xDEADBEEF in cycle 2, c_stall low in cycle 2.
REQ-035 Debug write: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x12345678. Required: m_wr_en=1 with m_addr=0x20 and m_wdata=0x12345678 in cycle 1, d_rvalid=1 with d_rdata=0 in cycle 2.
REQ-036 Contention, both reqs held for 4 accesses, round-robin build. Required: grant order core, debug, core, debug.
REQ-037 Contention, fixed-priority build. Required: all 4 grants go to core; d_gnt stays 0.
REQ-038 Late request: d_req raised during core ACCESS. Required: d_gnt in the IDLE cycle right after core RESP.
REQ-039 Reset mid-access: rst low in ACCESS. Required: m_wr_en=0 at once, no rvalid, busy=0; the next request after release is granted in 1 cycle.
